password_oracle: RTL

Responder side of the cracker guess protocol. Holds a secret password loaded byte-serially, accepts candidate guesses from `NUM_REQ` cracker instances over per-requester valid/ready, arbitrates round-robin, and returns a registered match response. It latches the first matching requester and guess, then stops accepting guesses. It sits beside `password_cracker_main` as the checking oracle that the crackers query.

---
 rtl/pw_oracle_pkg.sv | 18 +
 rtl/password_oracle_rr_arbiter.sv | 64 ++++++
 rtl/password_oracle.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pw_oracle_pkg.sv
// ---------------------------------------------------------------------------
// pw_oracle_pkg
// Shared definitions for the password oracle:
//   CHAR_W_DEF / PW_LEN_DEF : default character width and password length
//   IDX_W                   : width of a requester index (up to 16 requesters)
//   state_e                 : oracle state (LOAD, ARMED, FOUND)
// ---------------------------------------------------------------------------
package pw_oracle_pkg;
   localparam int CHAR_W_DEF = 8;
   localparam int PW_LEN_DEF = 4;
   localparam int IDX_W      = 4;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ARMED = 2'd1,
      FOUND = 2'd2
   } state_e;
endpackage

// File: rtl/password_oracle_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter across NUM_REQ requesters.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : request vector, one bit per requester
//   advance   : when high and a grant is made, the grant becomes the new
//               last-granted pointer
//   grant     : one-hot grant (combinational)
//   index     : index of the granted requester (combinational)
// The last-granted pointer resets to NUM_REQ-1 so requester 0 wins first.
// ---------------------------------------------------------------------------
module rr_arbiter
   import pw_oracle_pkg::*;
#(
   parameter int NUM_REQ = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   index
);

   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] hi_idx, lo_idx;
   logic             hi_hit, lo_hit, any_hit;

   // Lowest requester strictly above the pointer wins; otherwise wrap and
   // take the lowest requester at or below it. Scanning downwards leaves the
   // lowest qualifying index in each half.
   always_comb begin
      hi_hit = 1'b0;
      lo_hit = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (IDX_W'(i) > last_q) begin
               hi_hit = 1'b1;
               hi_idx = IDX_W'(i);
            end else begin
               lo_hit = 1'b1;
               lo_idx = IDX_W'(i);
            end
         end
      end
      any_hit = hi_hit | lo_hit;
      index   = hi_hit ? hi_idx : lo_idx;
      last_d  = (advance && any_hit) ? index : last_q;
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
         assign grant[gi] = any_hit && (index == IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= IDX_W'(NUM_REQ - 1);
      else     last_q <= last_d;
   end

endmodule

// File: rtl/password_oracle.sv
// ---------------------------------------------------------------------------
// password_oracle
// Checking oracle for the cracker guess protocol. A secret is loaded
// byte-serially (first byte = most significant character), then guesses from
// NUM_REQ requesters are arbitrated round-robin and answered one cycle later.
// The first match is latched and guessing stops until a new load begins.
//   clk, rst                   : clock, asynchronous active-high reset
//   load_valid/load_data/load_ready : secret byte stream
//   req_valid/req_guess/req_ready   : per-requester guess handshake
//   rsp_valid/rsp_id/rsp_match      : registered per-guess response pulse
//   found/found_id/found_guess      : sticky match record
//   armed                      : accepting guesses
//   attempts                   : saturating accepted-guess count
// Optional feature macro PW_ORACLE_ATTEMPT_CNT_EN builds the attempts counter;
// without it attempts is tied to zero.
// ---------------------------------------------------------------------------
module password_oracle
   import pw_oracle_pkg::*;
#(
   parameter  int NUM_REQ = 9,
   parameter  int PW_LEN  = PW_LEN_DEF,
   parameter  int CHAR_W  = CHAR_W_DEF,
   localparam int PW_W    = PW_LEN * CHAR_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_valid,
   input  logic [CHAR_W-1:0]         load_data,
   output logic                      load_ready,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*PW_W-1:0]   req_guess,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rsp_valid,
   output logic [IDX_W-1:0]          rsp_id,
   output logic                      rsp_match,
   output logic                      found,
   output logic [IDX_W-1:0]          found_id,
   output logic [PW_W-1:0]           found_guess,
   output logic                      armed,
   output logic [31:0]               attempts
);

   localparam int CNT_W = $clog2(PW_LEN + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW_W-1:0]  secret_q, secret_d;
   logic [PW_W-1:0]  found_guess_q, found_guess_d;
   logic [IDX_W-1:0] found_id_q, found_id_d;
   logic [IDX_W-1:0] rsp_id_q, rsp_id_d;
   logic             found_q, found_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_match_q, rsp_match_d;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic [PW_W-1:0]    sel_guess;
   logic               accept, is_match, load_fire, is_armed;

   assign is_armed = (state_q == ARMED);

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (is_armed),
      .grant   (grant),
      .index   (grant_idx)
   );

   always_comb begin
      sel_guess = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == IDX_W'(i)) sel_guess = req_guess[i*PW_W +: PW_W];
      end
   end

   assign accept    = is_armed && (|grant);
   assign is_match  = (sel_guess == secret_q);
   assign load_fire = load_valid && !is_armed;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      secret_d      = secret_q;
      found_d       = found_q;
      found_id_d    = found_id_q;
      found_guess_d = found_guess_q;
      rsp_valid_d   = 1'b0;
      rsp_match_d   = 1'b0;
      rsp_id_d      = rsp_id_q;

      // Shifting in from the LSB side leaves the first byte on top once all
      // PW_LEN bytes are in; stale bytes from an earlier secret fall off.
      if (load_fire) secret_d = (secret_q << CHAR_W) | PW_W'(load_data);

      case (state_q)
         LOAD: begin
            if (load_valid) begin
               if (cnt_q == CNT_W'(PW_LEN - 1)) begin
                  state_d = ARMED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ARMED: begin
            if (accept) begin
               rsp_valid_d = 1'b1;
               rsp_id_d    = grant_idx;
               rsp_match_d = is_match;
               if (is_match) begin
                  found_d       = 1'b1;
                  found_id_d    = grant_idx;
                  found_guess_d = sel_guess;
                  state_d       = FOUND;
               end
            end
         end
         FOUND: begin
            // The first byte of a new secret also retires the old match.
            if (load_valid) begin
               found_d = 1'b0;
               if (PW_LEN == 1) begin
                  state_d = ARMED;
                  cnt_d   = '0;
               end else begin
                  state_d = LOAD;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= LOAD;
         cnt_q         <= '0;
         secret_q      <= '0;
         found_q       <= 1'b0;
         found_id_q    <= '0;
         found_guess_q <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_match_q   <= 1'b0;
         rsp_id_q      <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         secret_q      <= secret_d;
         found_q       <= found_d;
         found_id_q    <= found_id_d;
         found_guess_q <= found_guess_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_match_q   <= rsp_match_d;
         rsp_id_q      <= rsp_id_d;
      end
   end

`ifdef PW_ORACLE_ATTEMPT_CNT_EN
   logic [31:0] attempts_q, attempts_d;

   always_comb begin
      attempts_d = attempts_q;
      if (load_fire && (state_q == FOUND))     attempts_d = '0;
      else if (accept && (attempts_q != '1))   attempts_d = attempts_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) attempts_q <= '0;
      else     attempts_q <= attempts_d;
   end

   assign attempts = attempts_q;
`else
   assign attempts = '0;
`endif

   assign load_ready  = !is_armed;
   assign req_ready   = is_armed ? grant : '0;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_match   = rsp_match_q;
   assign found       = found_q;
   assign found_id    = found_id_q;
   assign found_guess = found_guess_q;
   assign armed       = is_armed;

endmodule
